spike_peak_detect: RTL and testbench
====================================

// Module: spike_peak_detect
// PURPOSE
//  Downstream of the reference-subtraction stage: consumes the muar stream (t, ch, muar, ch_hash, thr),
//  runs a per-channel negative-threshold spike detector with peak tracking and refractory lockout,
//  emits one event per spike (peak time, ch, peak value, ch_hash). Per-channel state held in a RAM,
//  read-modify-write pipelined; no backpressure (upstream TREADY tied 1).
// PARAMETERS
//  N_CH         160  channels served; ch >= N_CH is dropped
//  REFRAC_LEN   10   samples (per channel) ignored after a spike is emitted, 1..2^CNT_W-1
//  MAX_SPK_LEN  8    max samples in PEAK before forced emit, 1..2^CNT_W-1
//  CNT_W        8    width of per-channel sample counter
// PORTS
//  clk           in   1   clock; single clock domain
//  rst           in   1   reset, asynchronous, active-high
//  muar_valid    in   1   input sample valid, one sample per cycle max
//  muar_frame_No in   32  frame number t
//  muar_ch       in   12  channel number
//  muar_data     in   32  signed ref-subtracted sample
//  muar_ch_hash  in   32  channel hash, passed through with the peak
//  muar_thr      in   32  signed threshold (negative for normal use)
//  spk_valid     out  1   one-cycle spike event strobe
//  spk_frame_No  out  32  frame number of the peak sample
//  spk_ch        out  12  channel of the spike
//  spk_peak      out  32  signed peak (minimum) value
//  spk_ch_hash   out  32  ch_hash of the sample that closed the spike
//  init_done     out  1   state RAM cleared, samples accepted
//  drop_cnt      out  16  saturating count of samples dropped (init sweep or ch >= N_CH)
// BEHAVIOUR
//  - Reset: all outputs 0; pipeline valids 0; init sweep restarts. Reset mid-operation discards in-flight samples.
//  - Init sweep: after rst deasserts, write IDLE entry to addresses 0..N_CH-1, one per cycle; init_done=1 the
//    cycle after address N_CH-1 written. Samples with muar_valid during sweep dropped, drop_cnt+1.
//  - Entry per ch: state{IDLE,PEAK,REFRAC}, min[31:0], tmin[31:0], cnt[CNT_W-1:0]. Signed compare throughout.
//  - Pipeline: S0 register input + RAM read addr; S1 RAM read data (sync read, 1 cycle); S2 compute, write back,
//    emit. Latency muar_valid -> spk_valid = 3 cycles for the closing sample.
//  - Hazard: if S2 writes ch X and S0/S1 holds ch X, the S2 write-back entry is forwarded (covers back-to-back
//    same-ch samples, including single-channel streams); RAM read value never used stale.
//  - IDLE:   data < thr -> PEAK, min=data, tmin=frame, cnt=1. Else stay.
//  - PEAK:   data < thr and cnt < MAX_SPK_LEN -> if data < min: min=data, tmin=frame (tie keeps earlier tmin); cnt+1.
//            data >= thr or cnt == MAX_SPK_LEN -> emit {tmin, ch, min, ch_hash}; -> REFRAC, cnt=REFRAC_LEN.
//            Sample that closes the spike is not compared as a new crossing.
//  - REFRAC: sample ignored, cnt-1; cnt reaching 0 -> IDLE (next sample on that ch evaluated normally).
//  - ch >= N_CH: no RAM access, no emit, drop_cnt+1. drop_cnt saturates at 16'hFFFF.
//  - At most one emit per cycle (one input per cycle); spk_* hold last event values when spk_valid=0.
// STRUCTURE
//  - Package spike_pkg: state enum (IDLE=0,PEAK=1,REFRAC=2), entry struct, ENTRY_W, field widths.
//  - Sub-module spk_state_ram: simple dual-port, 1 write + 1 sync-read port, depth N_CH, width ENTRY_W, no reset.
//  - Top: init sweep counter, 3-stage pipeline, forwarding mux, per-channel FSM update, output regs.
// TESTING
//  1 Reset/init: rst pulse, N_CH=160 -> init_done rises 161 cycles after deassert; valid in sweep -> drop_cnt=1.
//  2 Single spike ch5 thr=-100: data 0,-150,-300,-200,50 at t=10..14 -> one spk: t=12, ch=5, peak=-300, 3 cyc after t=14 sample.
//  3 Refractory ch5: after test 2, 10 samples of -500 -> no spk; 11th sample -500 -> PEAK entered, spk later.
//  4 MAX_SPK_LEN: ch7 data -200 constant, thr=-100 -> spk after 8th PEAK sample, peak=-200, tmin=first sample t.
//  5 Hazard: ch3 only, back-to-back cycles, data -150,-400,-120,0 -> one spk peak=-400 (forwarding exercised).
//  6 Interleave 160 ch + ch=200 sample -> per-ch independent events, drop_cnt+1, no spk for ch 200.

Source files
------------

// File: rtl/spike_pkg.sv
// ============================================================================
// spike_pkg : per-channel spike detector entry layout and shared helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package spike_pkg;

   localparam int CNT_W  = 8;
   localparam int DATA_W = 32;
   localparam int CH_W   = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEAK   = 2'd1,
      ST_REFRAC = 2'd2
   } spk_state_e;

   typedef struct packed {
      spk_state_e        state;
      logic [DATA_W-1:0] min_val;
      logic [DATA_W-1:0] tmin;
      logic [CNT_W-1:0]  cnt;
   } spk_entry_t;

   localparam int ENTRY_W = $bits(spk_entry_t);

   function automatic logic lt_s(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return $signed(a) < $signed(b);
   endfunction

endpackage

`default_nettype wire

// File: rtl/spk_state_ram.sv
// ============================================================================
// spk_state_ram : simple dual-port state RAM, one write port, one sync read port
// Rev 1.0
// ============================================================================
`default_nettype none

module spk_state_ram #(
   parameter int DEPTH = 160,
   parameter int WIDTH = 74,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Read returns the pre-write contents on an address collision.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

`default_nettype wire

// File: rtl/spike_peak_detect.sv
// ============================================================================
// spike_peak_detect : per-channel negative-threshold spike detector with peak
// tracking and refractory lockout; 3-stage RMW pipeline over a state RAM.
// Rev 1.0
// ============================================================================
`default_nettype none

module spike_peak_detect
   import spike_pkg::*;
#(
   parameter int N_CH        = 160,
   parameter int REFRAC_LEN  = 10,
   parameter int MAX_SPK_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              muar_valid,
   input  logic [31:0]       muar_frame_No,
   input  logic [CH_W-1:0]   muar_ch,
   input  logic [DATA_W-1:0] muar_data,
   input  logic [31:0]       muar_ch_hash,
   input  logic [DATA_W-1:0] muar_thr,
   output logic              spk_valid,
   output logic [31:0]       spk_frame_No,
   output logic [CH_W-1:0]   spk_ch,
   output logic [DATA_W-1:0] spk_peak,
   output logic [31:0]       spk_ch_hash,
   output logic              init_done,
   output logic [15:0]       drop_cnt
);

   localparam int               c_AW      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CH_W-1:0]  c_N_CH    = CH_W'(N_CH);
   localparam logic [c_AW-1:0]  c_LAST    = c_AW'(N_CH - 1);
   localparam logic [CNT_W-1:0] c_MAX_LEN = CNT_W'(MAX_SPK_LEN);
   localparam logic [CNT_W-1:0] c_REFRAC  = CNT_W'(REFRAC_LEN);
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

   logic [c_AW-1:0]   r_init_addr;

   logic              r_s0_valid;
   logic [31:0]       r_s0_frame;
   logic [CH_W-1:0]   r_s0_ch;
   logic [DATA_W-1:0] r_s0_data;
   logic [31:0]       r_s0_hash;
   logic [DATA_W-1:0] r_s0_thr;

   logic              r_s1_valid;
   logic [31:0]       r_s1_frame;
   logic [CH_W-1:0]   r_s1_ch;
   logic [DATA_W-1:0] r_s1_data;
   logic [31:0]       r_s1_hash;
   logic [DATA_W-1:0] r_s1_thr;
   logic              r_s1_fwd_valid;
   spk_entry_t        r_s1_fwd_entry;

   logic              r_s2_valid;
   logic              r_s2_emit;
   logic [CH_W-1:0]   r_s2_ch;
   logic [31:0]       r_s2_hash;
   spk_entry_t        r_s2_entry;

   logic              w_accept;
   logic              w_drop;
   logic              w_ram_we;
   logic [c_AW-1:0]   w_ram_waddr;
   logic [ENTRY_W-1:0] w_ram_wdata;
   logic [ENTRY_W-1:0] w_ram_rdata;
   spk_entry_t        w_rd_entry;
   spk_entry_t        w_cur;
   spk_entry_t        w_next;
   logic              w_emit;
   logic              w_below;

   assign w_accept = muar_valid && init_done && (muar_ch < c_N_CH);
   assign w_drop   = muar_valid && !w_accept;

   // The init sweep owns the write port until every entry has been cleared.
   assign w_ram_we    = !init_done || r_s2_valid;
   assign w_ram_waddr = init_done ? r_s2_ch[c_AW-1:0] : r_init_addr;
   assign w_ram_wdata = init_done ? r_s2_entry : '0;

   spk_state_ram #(
      .DEPTH (N_CH),
      .WIDTH (ENTRY_W),
      .AW    (c_AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_raddr (r_s0_ch[c_AW-1:0]),
      .o_rdata (w_ram_rdata)
   );

   assign w_rd_entry = spk_entry_t'(w_ram_rdata);

   // Newest copy wins: in-flight S2 write, then a write that collided with our read, then RAM.
   always_comb begin
      w_cur = w_rd_entry;
      if (r_s2_valid && (r_s2_ch == r_s1_ch)) begin
         w_cur = r_s2_entry;
      end else if (r_s1_fwd_valid) begin
         w_cur = r_s1_fwd_entry;
      end
   end

   assign w_below = lt_s(r_s1_data, r_s1_thr);

   always_comb begin
      w_next = w_cur;
      w_emit = 1'b0;
      case (w_cur.state)
         ST_PEAK: begin
            if (w_below && (w_cur.cnt < c_MAX_LEN)) begin
               if (lt_s(r_s1_data, w_cur.min_val)) begin
                  w_next.min_val = r_s1_data;
                  w_next.tmin    = r_s1_frame;
               end
               w_next.cnt = w_cur.cnt + c_ONE;
            end else begin
               w_emit       = 1'b1;
               w_next.state = ST_REFRAC;
               w_next.cnt   = c_REFRAC;
            end
         end
         ST_REFRAC: begin
            w_next.cnt = w_cur.cnt - c_ONE;
            if (w_cur.cnt <= c_ONE) begin
               w_next.state = ST_IDLE;
               w_next.cnt   = '0;
            end
         end
         default: begin
            if (w_below) begin
               w_next.state   = ST_PEAK;
               w_next.min_val = r_s1_data;
               w_next.tmin    = r_s1_frame;
               w_next.cnt     = c_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_init_addr <= '0;
         init_done   <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         if (!init_done) begin
            r_init_addr <= r_init_addr + c_AW'(1);
            if (r_init_addr == c_LAST) begin
               init_done <= 1'b1;
            end
         end
         if (w_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0_valid     <= 1'b0;
         r_s0_frame     <= '0;
         r_s0_ch        <= '0;
         r_s0_data      <= '0;
         r_s0_hash      <= '0;
         r_s0_thr       <= '0;
         r_s1_valid     <= 1'b0;
         r_s1_frame     <= '0;
         r_s1_ch        <= '0;
         r_s1_data      <= '0;
         r_s1_hash      <= '0;
         r_s1_thr       <= '0;
         r_s1_fwd_valid <= 1'b0;
         r_s1_fwd_entry <= '0;
         r_s2_valid     <= 1'b0;
         r_s2_emit      <= 1'b0;
         r_s2_ch        <= '0;
         r_s2_hash      <= '0;
         r_s2_entry     <= '0;
      end else begin
         r_s0_valid <= w_accept;
         r_s0_frame <= muar_frame_No;
         r_s0_ch    <= muar_ch;
         r_s0_data  <= muar_data;
         r_s0_hash  <= muar_ch_hash;
         r_s0_thr   <= muar_thr;

         r_s1_valid     <= r_s0_valid;
         r_s1_frame     <= r_s0_frame;
         r_s1_ch        <= r_s0_ch;
         r_s1_data      <= r_s0_data;
         r_s1_hash      <= r_s0_hash;
         r_s1_thr       <= r_s0_thr;
         // S0 read and S2 write hit the same address on this edge, so the RAM returns old data.
         r_s1_fwd_valid <= r_s0_valid && r_s2_valid && (r_s2_ch == r_s0_ch);
         r_s1_fwd_entry <= r_s2_entry;

         r_s2_valid <= r_s1_valid;
         r_s2_emit  <= r_s1_valid && w_emit;
         r_s2_ch    <= r_s1_ch;
         r_s2_hash  <= r_s1_hash;
         r_s2_entry <= w_next;
      end
   end

   // A closing entry still carries the finished spike's min/tmin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spk_valid    <= 1'b0;
         spk_frame_No <= '0;
         spk_ch       <= '0;
         spk_peak     <= '0;
         spk_ch_hash  <= '0;
      end else begin
         spk_valid <= r_s2_emit;
         if (r_s2_emit) begin
            spk_frame_No <= r_s2_entry.tmin;
            spk_ch       <= r_s2_ch;
            spk_peak     <= r_s2_entry.min_val;
            spk_ch_hash  <= r_s2_hash;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spike_peak_detect.sv
// ============================================================================
// tb_spike_peak_detect : directed self-checking bench for spike_peak_detect
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spike_peak_detect;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        muar_valid = 1'b0;
   logic [31:0] muar_frame_No = '0;
   logic [11:0] muar_ch = '0;
   logic [31:0] muar_data = '0;
   logic [31:0] muar_ch_hash = '0;
   logic [31:0] muar_thr = '0;
   logic        spk_valid;
   logic [31:0] spk_frame_No;
   logic [11:0] spk_ch;
   logic [31:0] spk_peak;
   logic [31:0] spk_ch_hash;
   logic        init_done;
   logic [15:0] drop_cnt;

   typedef struct {
      int          cyc;
      logic [31:0] fr;
      logic [11:0] ch;
      logic [31:0] pk;
      logic [31:0] h;
   } ev_t;

   ev_t ev_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  last_in_cyc = 0;

   spike_peak_detect #(
      .N_CH        (160),
      .REFRAC_LEN  (10),
      .MAX_SPK_LEN (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .muar_valid    (muar_valid),
      .muar_frame_No (muar_frame_No),
      .muar_ch       (muar_ch),
      .muar_data     (muar_data),
      .muar_ch_hash  (muar_ch_hash),
      .muar_thr      (muar_thr),
      .spk_valid     (spk_valid),
      .spk_frame_No  (spk_frame_No),
      .spk_ch        (spk_ch),
      .spk_peak      (spk_peak),
      .spk_ch_hash   (spk_ch_hash),
      .init_done     (init_done),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         if (spk_valid === 1'b1) begin
            ev_q.push_back('{cyc, spk_frame_No, spk_ch, spk_peak, spk_ch_hash});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic send(input int ch, input int fr, input int data, input int thr, input int h);
      @(negedge clk);
      muar_valid    = 1'b1;
      muar_ch       = 12'(ch);
      muar_frame_No = fr;
      muar_data     = data;
      muar_thr      = thr;
      muar_ch_hash  = h;
      @(posedge clk);
      #1;
      last_in_cyc = cyc;
      muar_valid  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Cycle 0 after release writes addr 0; addr 159 lands on edge 160, so init_done is
   // first seen after edge 160 (the 161st cycle counting from release).
   task automatic test_reset(input bit with_drop);
      int n;
      bit done;
      int exp_drop;
      exp_drop = with_drop ? 1 : 0;
      @(negedge clk);
      rst = 1'b1;
      muar_valid = 1'b0;
      idle(2);
      checks++;
      if (spk_valid !== 1'b0) begin errors++; $display("FAIL reset_spk_valid: got %b expected 0", spk_valid); end
      checks++;
      if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
      checks++;
      if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
      checks++;
      if (spk_peak !== 32'd0 || spk_frame_No !== 32'd0) begin
         errors++; $display("FAIL reset_spk_fields: got peak %0d frame %0d expected 0 0", spk_peak, spk_frame_No);
      end
      @(negedge clk);
      rst = 1'b0;
      if (with_drop) begin
         muar_valid = 1'b1; muar_ch = 12'd5; muar_data = -1000; muar_thr = -100;
         muar_frame_No = 1; muar_ch_hash = 32'h1;
      end
      n = 0;
      done = 1'b0;
      ev_q.delete();
      while (!done && n < 400) begin
         @(posedge clk);
         n++;
         #1;
         muar_valid = 1'b0;
         if (init_done === 1'b1) done = 1'b1;
      end
      checks++;
      if (n != 160) begin errors++; $display("FAIL init_latency: got %0d edges expected 160", n); end
      checks++;
      if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL init_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
      idle(4);
      checks++;
      if (ev_q.size() != 0) begin errors++; $display("FAIL init_no_spike: got %0d events expected 0", ev_q.size()); end
   endtask

   task automatic test_single_spike();
      int d[5] = '{0, -150, -300, -200, 50};
      int lat;
      ev_q.delete();
      for (int i = 0; i < 5; i++) send(5, 10 + i, d[i], -100, 32'hA500_0000 + 10 + i);
      lat = last_in_cyc;
      idle(6);
      checks++;
      if (ev_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", ev_q.size()); end
      if (ev_q.size() > 0) begin
         checks++;
         if (ev_q[0].fr !== 32'd12) begin errors++; $display("FAIL single_tmin: got %0d expected 12", ev_q[0].fr); end
         checks++;
         if (ev_q[0].ch !== 12'd5) begin errors++; $display("FAIL single_ch: got %0d expected 5", ev_q[0].ch); end
         checks++;
         if (ev_q[0].pk !== 32'(-300)) begin errors++; $display("FAIL single_peak: got %0d expected -300", $signed(ev_q[0].pk)); end
         checks++;
         if (ev_q[0].h !== 32'hA500_000E) begin errors++; $display("FAIL single_hash: got %h expected a500000e", ev_q[0].h); end
         checks++;
         if (ev_q[0].cyc - lat != 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", ev_q[0].cyc - lat); end
      end
   endtask

   task automatic test_refractory();
      ev_q.delete();
      for (int i = 0; i < 10; i++) send(5, 20 + i, -500, -100, 32'hC000_0000 + i);
      idle(6);
      checks++;
      if (ev_q.size() != 0) begin errors++; $display("FAIL refrac_quiet: got %0d events expected 0", ev_q.size()); end
      send(5, 30, -500, -100, 32'hC000_0030);
      send(5, 31, 0, -100, 32'hC000_0031);
      idle(6);
      checks++;
      if (ev_q.size() != 1) begin errors++; $display("FAIL refrac_count: got %0d expected 1", ev_q.size()); end
      if (ev_q.size() > 0) begin
         checks++;
         if (ev_q[0].fr !== 32'd30 || ev_q[0].pk !== 32'(-500) || ev_q[0].ch !== 12'd5) begin
            errors++; $display("FAIL refrac_event: got t=%0d peak=%0d ch=%0d expected 30 -500 5",
                               ev_q[0].fr, $signed(ev_q[0].pk), ev_q[0].ch);
         end
      end
   endtask

   task automatic test_max_len();
      int lat;
      ev_q.delete();
      for (int i = 0; i < 8; i++) send(7, 100 + i, -200, -100, 32'hB700_0000 + i);
      idle(6);
      checks++;
      if (ev_q.size() != 0) begin errors++; $display("FAIL maxlen_early: got %0d events expected 0", ev_q.size()); end
      send(7, 108, -200, -100, 32'hB700_0108);
      lat = last_in_cyc;
      idle(6);
      checks++;
      if (ev_q.size() != 1) begin errors++; $display("FAIL maxlen_count: got %0d expected 1", ev_q.size()); end
      if (ev_q.size() > 0) begin
         checks++;
         if (ev_q[0].fr !== 32'd100 || ev_q[0].pk !== 32'(-200) || ev_q[0].ch !== 12'd7) begin
            errors++; $display("FAIL maxlen_event: got t=%0d peak=%0d ch=%0d expected 100 -200 7",
                               ev_q[0].fr, $signed(ev_q[0].pk), ev_q[0].ch);
         end
         checks++;
         if (ev_q[0].h !== 32'hB700_0108 || ev_q[0].cyc - lat != 3) begin
            errors++; $display("FAIL maxlen_close: got hash %h lat %0d expected b7000108 3", ev_q[0].h, ev_q[0].cyc - lat);
         end
      end
   endtask

   task automatic test_hazard();
      int d[4] = '{-150, -400, -120, 0};
      ev_q.delete();
      for (int i = 0; i < 4; i++) send(3, 200 + i, d[i], -100, 32'hD300_0000 + i);
      idle(6);
      checks++;
      if (ev_q.size() != 1) begin errors++; $display("FAIL hazard_count: got %0d expected 1", ev_q.size()); end
      if (ev_q.size() > 0) begin
         checks++;
         if (ev_q[0].fr !== 32'd201 || ev_q[0].pk !== 32'(-400) || ev_q[0].ch !== 12'd3) begin
            errors++; $display("FAIL hazard_event: got t=%0d peak=%0d ch=%0d expected 201 -400 3",
                               ev_q[0].fr, $signed(ev_q[0].pk), ev_q[0].ch);
         end
      end
   endtask

   // Same channel two cycles apart: the later read collides with the earlier write-back.
   task automatic test_back_to_back();
      int chs[6] = '{9, 10, 9, 10, 9, 10};
      int d[6]   = '{-400, -300, -150, -250, 0, 0};
      ev_q.delete();
      for (int i = 0; i < 6; i++) send(chs[i], 300 + i, d[i], -100, 32'hE000_0000 + i);
      idle(6);
      checks++;
      if (ev_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", ev_q.size()); end
      if (ev_q.size() > 1) begin
         checks++;
         if (ev_q[0].ch !== 12'd9 || ev_q[0].fr !== 32'd300 || ev_q[0].pk !== 32'(-400)) begin
            errors++; $display("FAIL b2b_ch9: got ch=%0d t=%0d peak=%0d expected 9 300 -400",
                               ev_q[0].ch, ev_q[0].fr, $signed(ev_q[0].pk));
         end
         checks++;
         if (ev_q[1].ch !== 12'd10 || ev_q[1].fr !== 32'd301 || ev_q[1].pk !== 32'(-300)) begin
            errors++; $display("FAIL b2b_ch10: got ch=%0d t=%0d peak=%0d expected 10 301 -300",
                               ev_q[1].ch, ev_q[1].fr, $signed(ev_q[1].pk));
         end
      end
   endtask

   task automatic test_interleave();
      ev_q.delete();
      for (int c = 0; c < 160; c++) send(c, 1000, -(200 + c), -100, 32'hF000_0000 + c);
      send(200, 1000, -5000, -100, 32'hDEAD_0200);
      for (int c = 0; c < 160; c++) send(c, 1001, 0, -100, c);
      idle(6);
      checks++;
      if (ev_q.size() != 160) begin errors++; $display("FAIL ilv_count: got %0d expected 160", ev_q.size()); end
      checks++;
      if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ilv_drop_cnt: got %0d expected 1", drop_cnt); end
      for (int i = 0; i < ev_q.size() && i < 160; i++) begin
         checks++;
         if (ev_q[i].ch !== 12'(i) || ev_q[i].fr !== 32'd1000 || ev_q[i].pk !== 32'(-(200 + i)) || ev_q[i].h !== 32'(i)) begin
            errors++; $display("FAIL ilv_event%0d: got ch=%0d t=%0d peak=%0d hash=%0d expected %0d 1000 %0d %0d",
                               i, ev_q[i].ch, ev_q[i].fr, $signed(ev_q[i].pk), ev_q[i].h, i, -(200 + i), i);
         end
      end
   endtask

   initial begin
      test_reset(1'b1);
      test_single_spike();
      test_refractory();
      test_max_len();
      test_hazard();
      test_back_to_back();
      test_reset(1'b0);
      test_interleave();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
